// File: rtl/asip_pkg.sv
// Shared ASIP front-end definitions: address width, reset PC and sequencer states.
// Pure declarations; no logic, no latency, no flow control.
package asip_pkg;

    localparam int              ADDR_W   = 10;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug statistics; count updates one cycle after inc.
// No backpressure: inc is sampled every cycle, further increments at all-ones are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_branch_sequencer.sv
// PC sequencer: steps fetch address, redirects on taken branch with a timed flush, halt/resume.
// All outputs registered (1-cycle latency); stall freezes PC/fetch in RUN only, redirect overrides it.
module pc_branch_sequencer #(
    parameter int                ADDR_W       = asip_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = asip_pkg::RESET_PC,
    parameter int                FLUSH_CYCLES = 2,
    parameter int                CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_en,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  ntaken_cnt
);

    import asip_pkg::*;

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    seq_state_t        r_state;
    logic [FC_W-1:0]   r_fcnt;
    logic              r_halt_pend;

    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_fetch_nxt;
    logic              w_flush_nxt;
    logic              w_halted_nxt;
    logic [FC_W-1:0]   w_fcnt_nxt;
    logic              w_halt_pend_nxt;
    logic              w_inc_taken;
    logic              w_inc_ntaken;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = pc;
        w_fetch_nxt     = 1'b0;
        w_flush_nxt     = 1'b0;
        w_halted_nxt    = 1'b0;
        w_fcnt_nxt      = r_fcnt;
        w_halt_pend_nxt = r_halt_pend;
        w_inc_taken     = 1'b0;
        w_inc_ntaken    = 1'b0;

        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                w_fetch_nxt = 1'b1;
            end
            RUN: begin
                if (br_valid && br_taken) begin
                    w_state_nxt     = FLUSH;
                    w_pc_nxt        = br_target;
                    w_flush_nxt     = 1'b1;
                    w_fcnt_nxt      = FC_W'(FLUSH_CYCLES);
                    w_halt_pend_nxt = halt_req;
                    w_inc_taken     = 1'b1;
                end else begin
                    w_inc_ntaken = br_valid;
                    if (halt_req) begin
                        w_state_nxt  = HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_fetch_nxt = !stall;
                        if (!stall) begin
                            w_pc_nxt = pc + ADDR_W'(1);
                        end
                    end
                end
            end
            FLUSH: begin
                w_fcnt_nxt = r_fcnt - FC_W'(1);
                // A halt requested alongside the redirect is held until the window closes.
                if (r_fcnt <= FC_W'(1)) begin
                    w_halt_pend_nxt = 1'b0;
                    if (halt_req || r_halt_pend) begin
                        w_state_nxt  = HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_fetch_nxt = 1'b1;
                    end
                end else begin
                    w_flush_nxt = 1'b1;
                end
            end
            HALT: begin
                w_halted_nxt = 1'b1;
                if (resume && !halt_req) begin
                    w_state_nxt  = RUN;
                    w_halted_nxt = 1'b0;
                    w_fetch_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT;
            pc          <= RESET_PC;
            fetch_en    <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
            r_fcnt      <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            pc          <= w_pc_nxt;
            fetch_en    <= w_fetch_nxt;
            flush       <= w_flush_nxt;
            halted      <= w_halted_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_taken),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ntaken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_ntaken),
        .count (ntaken_cnt)
    );

endmodule
